// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared types and widths for the CPU pipeline stage registers.
//   EX_MEM_DATA_W / EX_MEM_CTRL_W : default widths of the EX/MEM boundary
//   ex_mem_ctrl_t                 : write-enable style control bits (zeroed on bubble)
//   ex_mem_data_t                 : non-control EX/MEM payload
//   pipe_state_e                  : occupancy state of a stage register
package pipe_pkg;

  localparam int EX_MEM_DATA_W = 133;
  localparam int EX_MEM_CTRL_W = 4;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] write_src;
    logic       mem_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] imm_op;
    logic [31:0] pc_plus4;
    logic [31:0] reg_op2;
    logic [4:0]  rd;
  } ex_mem_data_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready beat bus between two pipeline stages.
//   valid : beat valid (producer -> consumer)
//   ready : consumer can take the beat (consumer -> producer)
//   data  : non-control payload, DATA_W bits
//   ctrl  : control bits, CTRL_W bits
// Modports: master = producer side, slave = consumer side.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = EX_MEM_CTRL_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one beat of storage -- a valid bit plus data/ctrl payload.
//   clk_i, rst_ni : clock, async active-low reset (clears valid and payload)
//   load_i        : capture data_i/ctrl_i and set valid
//   clr_i         : drop valid only; payload is kept (wins over load_i)
//   vld_o/data_o/ctrl_o : stored beat
module pipe_slot #(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_o  <= 1'b0;
      data_o <= '0;
      ctrl_o <= '0;
    end else if (clr_i) begin
      vld_o  <= 1'b0;
    end else if (load_i) begin
      vld_o  <= 1'b1;
      data_o <= data_i;
      ctrl_o <= ctrl_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake,
// synchronous flush and optional skid buffer (macro PIPE_SKID_EN).
//   clk_i   : clock, all updates on posedge
//   rst_ni  : async active-low reset
//   flush_i : kill all held beats at this edge; an incoming beat is dropped,
//             an emit in the same cycle still completes
//   up      : upstream beat bus (slave): valid_i/ready_o/data_i/ctrl_i
//   dn      : downstream beat bus (master): valid_o/ready_i/data_o/ctrl_o
// ctrl_o is forced to zero whenever valid_o is low so a bubble never carries
// write enables. data_o holds its last value when empty.
// PIPE_SKID_EN defined  : second slot, ready_o comes straight from a flop.
// PIPE_SKID_EN undefined: single slot, ready_o = !valid_o || ready_i.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = EX_MEM_CTRL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn
);

  pipe_state_e state_q, state_d;

  logic              out_load, out_clr;
  logic              out_vld;
  logic [DATA_W-1:0] out_data, out_data_d;
  logic [CTRL_W-1:0] out_ctrl, out_ctrl_d;
  logic              accept, emit;

  assign accept = up.valid && up.ready;
  assign emit   = out_vld && dn.ready;

`ifdef PIPE_SKID_EN
  logic              skid_load, skid_clr, out_from_skid;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Registered ready: only the skid flop decides, so no ready_i -> ready_o path.
  assign up.ready   = !skid_vld;
  assign out_data_d = out_from_skid ? skid_data : up.data;
  assign out_ctrl_d = out_from_skid ? skid_ctrl : up.ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .data_i (up.data),
    .ctrl_i (up.ctrl),
    .vld_o  (skid_vld),
    .data_o (skid_data),
    .ctrl_o (skid_ctrl)
  );
`else
  assign up.ready   = !out_vld || dn.ready;
  assign out_data_d = up.data;
  assign out_ctrl_d = up.ctrl;
`endif

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_out (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (out_load),
    .clr_i  (out_clr),
    .data_i (out_data_d),
    .ctrl_i (out_ctrl_d),
    .vld_o  (out_vld),
    .data_o (out_data),
    .ctrl_o (out_ctrl)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    out_load = 1'b0;
    out_clr  = 1'b0;
`ifdef PIPE_SKID_EN
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    out_from_skid = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_load = 1'b1;
          state_d  = FULL;
        end
      end
      FULL: begin
        if (emit && accept) begin
          out_load = 1'b1;
        end else if (emit) begin
          out_clr = 1'b1;
          state_d = EMPTY;
        end
`ifdef PIPE_SKID_EN
        else if (accept) begin
          // Downstream stalled: park the new beat behind the output slot.
          skid_load = 1'b1;
          state_d   = SKID;
        end
`endif
      end
`ifdef PIPE_SKID_EN
      SKID: begin
        if (emit) begin
          out_load      = 1'b1;
          out_from_skid = 1'b1;
          skid_clr      = 1'b1;
          state_d       = FULL;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase

    // Flush overrides everything: no loads, both slots invalidated.
    if (flush_i) begin
      state_d  = EMPTY;
      out_load = 1'b0;
      out_clr  = 1'b1;
`ifdef PIPE_SKID_EN
      skid_load = 1'b0;
      skid_clr  = 1'b1;
`endif
    end
  end

  assign dn.valid = out_vld;
  assign dn.data  = out_data;
  assign dn.ctrl  = out_vld ? out_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DW = 133;
  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [CW-1:0] ctrl_i = '0;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  assign up_if.valid = valid_i;
  assign up_if.data  = data_i;
  assign up_if.ctrl  = ctrl_i;
  assign dn_if.ready = ready_i;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .up      (up_if),
    .dn      (dn_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue of held beats ----------------
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  beat_t held[$];
  beat_t last_out = '0;
  logic  m_acc, m_emt;

  function automatic logic m_ready();
    if (DEPTH == 2) return held.size() < 2;
    return (held.size() == 0) || ready_i;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      held.delete();
      last_out = '0;
    end else begin
      m_acc = valid_i && m_ready();
      m_emt = (held.size() > 0) && ready_i;
      if (m_emt) void'(held.pop_front());
      if (flush_i) held.delete();
      else if (m_acc) held.push_back({ctrl_i, data_i});
      if (held.size() > 0) last_out = held[0];
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("valid_o", 136'(dn_if.valid), 136'(held.size() > 0));
    chk("ready_o", 136'(up_if.ready), 136'(m_ready()));
    chk("ctrl_o",  136'(dn_if.ctrl),  136'((held.size() > 0) ? held[0].c : '0));
    chk("data_o",  136'(dn_if.data),  136'(last_out.d));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW; k++) d[k] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  logic [DW-1:0] aa_pat;
  int            cnt;

  initial begin
    for (int k = 0; k < DW; k++) aa_pat[k] = 1'(k % 2);

    // Reset with a beat pending upstream.
    valid_i = 1'b1; data_i = aa_pat; ctrl_i = 4'b1011; ready_i = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", 136'(dn_if.valid), 136'(0));
    chk("rst_data",  136'(dn_if.data),  136'(0));
    chk("rst_ctrl",  136'(dn_if.ctrl),  136'(0));
    chk("rst_ready", 136'(up_if.ready), 136'(1));
    rst_ni = 1'b1;
    cyc();
    chk("first_valid", 136'(dn_if.valid), 136'(1));
    chk("first_data",  136'(dn_if.data),  136'(aa_pat));
    chk("first_ctrl",  136'(dn_if.ctrl),  136'(4'b1011));
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) cyc();

    // Streaming: one beat per cycle, 1-cycle latency.
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; data_i = DW'(i); ctrl_i = 4'b1011;
      cyc();
      chk("stream_valid", 136'(dn_if.valid), 136'(1));
      chk("stream_data",  136'(dn_if.data),  136'(i));
      chk("stream_ctrl",  136'(dn_if.ctrl),  136'(4'b1011));
    end
    valid_i = 1'b0;
    repeat (2) cyc();
    chk("drain_ctrl", 136'(dn_if.ctrl), 136'(0));
    chk("drain_data", 136'(dn_if.data), 136'(7));

    // Backpressure: 3-cycle stall mid-stream.
    for (int i = 0; i < 12; i++) begin
      valid_i = 1'b1; data_i = DW'(200 + i); ctrl_i = 4'(i);
      ready_i = !(i >= 3 && i <= 5);
      if (i == 3) begin
        #0;
`ifdef PIPE_SKID_EN
        chk("stall_ready_skid", 136'(up_if.ready), 136'(1));
`else
        chk("stall_ready_noskid", 136'(up_if.ready), 136'(0));
`endif
      end
      cyc();
    end

    // Flush while full (and with skid, while two beats are held).
    ready_i = 1'b0; valid_i = 1'b1; data_i = DW'(300); ctrl_i = 4'hF;
    repeat (3) cyc();
    flush_i = 1'b1; ready_i = 1'b1; data_i = DW'(301);
    cyc();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_valid", 136'(dn_if.valid), 136'(0));
    chk("flush_ctrl",  136'(dn_if.ctrl),  136'(0));
    repeat (2) cyc();

    // Toggling ready_i with continuous valid_i.
    cnt = 400;
    for (int i = 0; i < 40; i++) begin
      valid_i = 1'b1; ready_i = (i % 2) == 0; data_i = DW'(cnt); ctrl_i = 4'(cnt);
      cnt++;
      cyc();
    end

    // Async reset while stalled with beats held.
    ready_i = 1'b0; valid_i = 1'b1; data_i = DW'(500); ctrl_i = 4'b0110;
    repeat (3) cyc();
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 136'(dn_if.valid), 136'(0));
    chk("arst_ctrl",  136'(dn_if.ctrl),  136'(0));
    chk("arst_ready", 136'(up_if.ready), 136'(1));
    chk("arst_data",  136'(dn_if.data),  136'(0));
    cyc();
    rst_ni = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      valid_i = 1'($urandom_range(0, 3) != 0);
      ready_i = 1'($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      data_i  = rand_data();
      ctrl_i  = 4'($urandom_range(0, 15));
      cyc();
    end
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and optional skid buffer. Generalises the fixed EX/MEM register: any payload width, per-stage stall via backpressure, and bubble insertion with write-enable control bits forced inactive. Instantiated between every pair of CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with widths set per boundary.

## Interface
- DATA_W, 133, non-control payload bits (EX/MEM: ALUout, ImmOp, pcPlus4, regOp2 at 32 each, plus rd at 5)
- CTRL_W, 4, control bits zeroed on bubble (EX/MEM: RegWrite, WriteSrc[1:0], MemWrite)
- clk_i  in  1  single clock, all state updates on posedge
- rst_ni  in  1  asynchronous, active-low reset
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept a beat
- data_i  in  DATA_W  upstream payload
- ctrl_i  in  CTRL_W  upstream control
- flush_i  in  1  synchronous kill of all held beats (branch mispredict/exception)
- valid_o  out  1  downstream beat valid
- ready_i  in  1  downstream accepts
- data_o  out  DATA_W  held payload
- ctrl_o  out  CTRL_W  held control, all-zero whenever valid_o=0

## Operation
- Accept: valid_i && ready_o at posedge. Emit: valid_o && ready_i at posedge.
- States: EMPTY (no beat held), FULL (output slot valid), SKID (output and skid slots valid; skid build only).
- EMPTY: accept -> FULL; else stay.
- FULL: emit and accept -> FULL (new beat); emit only -> EMPTY; accept only -> SKID (skid build), impossible otherwise since ready_o=0; neither -> FULL, payload held stable.
- SKID: ready_o=0; emit -> FULL with skid payload moved to output slot.
- flush_i=1: next state EMPTY regardless of other inputs; any beat accepted that cycle is dropped; an emit in the same cycle still completes downstream.
- ctrl_o = valid_o ? ctrl_reg : '0. data_o keeps last value when empty (not cleared), only reset zeroes it.
- Output payload changes only on an edge with a load; never changes while valid_o && !ready_i.
- Reset (rst_ni=0, immediate): valid_o=0, ctrl_o=0, data_o=0, skid slot empty, ready_o=1, state EMPTY.

## Timing
- Latency 1 cycle from accept to valid_o, in both builds.
- Throughput 1 beat/cycle while ready_i=1.
- Without skid: ready_o = !valid_o || ready_i, combinational path from ready_i.
- With skid: ready_o = !skid_valid, driven from a flop; no combinational ready_i -> ready_o path.
- Reset deassertion mid-stream: first accept possible on the first posedge after rst_ni rises.
- flush_i takes effect at the edge it is sampled; valid_o=0 and ctrl_o=0 from the next cycle.

## Configuration
- PIPE_SKID_EN defined: second slot present, SKID state used, ready_o registered, full throughput under toggling ready_i.
- PIPE_SKID_EN undefined: single slot, SKID state absent, ready_o combinational as above; same latency and flush behaviour.

## Structure
- pipe_pkg holds: EX_MEM_DATA_W=133, EX_MEM_CTRL_W=4, packed struct ex_mem_ctrl_t {RegWrite, WriteSrc[1:0], MemWrite}, ex_mem_data_t, and the state enum pipe_state_e {EMPTY, FULL, SKID}.
- One sub-module, pipe_slot: valid bit plus DATA_W+CTRL_W payload register with load/clear/async reset. Instantiated once for output, and a second time for the skid slot when PIPE_SKID_EN is defined.

## Test plan
- Reset: hold rst_ni=0 with valid_i=1, data_i=0xAA..., then release -> valid_o=0, ctrl_o=0, data_o=0, ready_o=1; beat appears on valid_o exactly 1 cycle after the first post-reset accept.
- Streaming: 8 beats, ctrl_i=4'b1011, data_i=i, ready_i=1 -> 8 outputs in order, one per cycle, 1-cycle latency.
- Backpressure: ready_i=0 for 3 cycles mid-stream -> data_o stable. Skid build: exactly 2 beats held, ready_o falls 1 cycle after stall. No-skid build: ready_o=0 during stall. No loss or duplication.
- Flush: flush_i=1 while FULL (and SKID) with valid_i=1 -> next cycle valid_o=0, ctrl_o=0, incoming beat dropped; a ready_i=1 emit in the flush cycle is counted once.
- Toggling ready_i (1,0,1,0...) with continuous valid_i -> skid build: ready_o never combinationally follows ready_i, all beats delivered in order.
- Async reset mid-stall in SKID: rst_ni low between edges -> valid_o and ctrl_o drop immediately, skid cleared.
